// File: rtl/icb_pkg.sv
// Shared ICB definitions: bus field widths and the routing-FIFO entry format.
package icb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;
  localparam int SEL_W  = 3;

  // One outstanding transaction: where its response must come from.
  typedef struct packed {
    logic             decerr;
    logic [SEL_W-1:0] sel;
  } route_t;

endpackage

// File: rtl/icb_route_fifo.sv
// First-word-fall-through routing FIFO holding one route entry per
// outstanding command. Flags are registered so a full FIFO refuses a push
// even in a cycle where it is also being popped.
module icb_route_fifo
  import icb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  route_t     din,
  input  logic       pop,
  output route_t     head,
  output logic       full_n,
  output logic       empty_n,
  output logic [4:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [4:0]    CNT_MAX = 5'(DEPTH);

  route_t        mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;
  logic [4:0]    count_nxt;

  assign do_push = push & full_n;
  assign do_pop  = pop & empty_n;
  assign head    = mem[rptr];

  // Occupancy after this cycle's push/pop; drives the registered flags.
  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + 5'd1;
    else if (!do_push && do_pop)
      count_nxt = count - 5'd1;
  end

  // Pointers, count and flags; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      full_n  <= 1'b1;
      empty_n <= 1'b0;
    end else begin
      if (do_push)
        wptr <= wptr + PTR_ONE;
      if (do_pop)
        rptr <= rptr + PTR_ONE;
      count   <= count_nxt;
      full_n  <= (count_nxt != CNT_MAX);
      empty_n <= (count_nxt != 5'd0);
    end
  end

  // Entry storage; contents are only observed while empty_n is set.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wptr] <= din;
  end

endmodule

// File: rtl/icb_1s_to_nm.sv
// ICB one-slave-to-N-master address splitter. Commands pass through
// combinationally to the decoded master; responses are returned strictly in
// command order using a routing FIFO. Unmapped addresses can be answered
// locally with an error response.
module icb_1s_to_nm
  import icb_pkg::*;
#(
  parameter int               MASTER_N         = 3,
  parameter logic [8*32-1:0]  BASEADDR         = {8{32'h0}},
  parameter logic [8*32-1:0]  ADDR_RANGE       = {8{32'h1000}},
  parameter int               OUTSTD_DEPTH     = 4,
  parameter bit               DECERR_EN        = 1'b1,
  // Retained for drop-in compatibility; the RTL itself is zero-delay.
  parameter int               simulation_delay = 1
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic [ADDR_W-1:0]            s_icb_cmd_addr,
  input  logic                         s_icb_cmd_read,
  input  logic [DATA_W-1:0]            s_icb_cmd_wdata,
  input  logic [MASK_W-1:0]            s_icb_cmd_wmask,
  input  logic                         s_icb_cmd_valid,
  output logic                         s_icb_cmd_ready,

  output logic [DATA_W-1:0]            s_icb_rsp_rdata,
  output logic                         s_icb_rsp_err,
  output logic                         s_icb_rsp_valid,
  input  logic                         s_icb_rsp_ready,

  output logic [MASTER_N*ADDR_W-1:0]   m_icb_cmd_addr,
  output logic [MASTER_N-1:0]          m_icb_cmd_read,
  output logic [MASTER_N*DATA_W-1:0]   m_icb_cmd_wdata,
  output logic [MASTER_N*MASK_W-1:0]   m_icb_cmd_wmask,
  output logic [MASTER_N-1:0]          m_icb_cmd_valid,
  input  logic [MASTER_N-1:0]          m_icb_cmd_ready,

  input  logic [MASTER_N*DATA_W-1:0]   m_icb_rsp_rdata,
  input  logic [MASTER_N-1:0]          m_icb_rsp_err,
  input  logic [MASTER_N-1:0]          m_icb_rsp_valid,
  output logic [MASTER_N-1:0]          m_icb_rsp_ready,

  output logic [4:0]                   outstd_cnt,
  output logic                         decerr_pulse
);

  logic [MASTER_N-1:0] hit;
  logic [MASTER_N-1:0] sel_oh;
  logic [SEL_W-1:0]    sel;
  logic                decerr;
  logic                cmd_ready_sel;
  logic                cmd_fire;
  logic                rsp_fire;
  logic                fifo_full_n;
  logic                head_vld;
  route_t              route_in;
  route_t              head;

  // Region hit per master, in 33-bit arithmetic so base+range never wraps.
  always_comb begin
    for (int i = 0; i < MASTER_N; i++) begin
      hit[i] = ({1'b0, s_icb_cmd_addr} >= {1'b0, BASEADDR[32*i +: 32]}) &&
               ({1'b0, s_icb_cmd_addr} <  ({1'b0, BASEADDR[32*i +: 32]} +
                                           {1'b0, ADDR_RANGE[32*i +: 32]}));
    end
  end

  // Lowest-index hit wins; a miss falls to the last master or a local error.
  always_comb begin
    sel = SEL_W'(MASTER_N - 1);
    for (int i = MASTER_N - 1; i >= 0; i--) begin
      if (hit[i])
        sel = SEL_W'(i);
    end
    decerr = DECERR_EN && (hit == '0);
    for (int i = 0; i < MASTER_N; i++)
      sel_oh[i] = (sel == SEL_W'(i));
  end

  // Command payload fans out to every master; only valid is steered.
  assign m_icb_cmd_addr  = {MASTER_N{s_icb_cmd_addr}};
  assign m_icb_cmd_read  = {MASTER_N{s_icb_cmd_read}};
  assign m_icb_cmd_wdata = {MASTER_N{s_icb_cmd_wdata}};
  assign m_icb_cmd_wmask = {MASTER_N{s_icb_cmd_wmask}};

  assign cmd_ready_sel   = |(m_icb_cmd_ready & sel_oh);
  assign m_icb_cmd_valid = {MASTER_N{s_icb_cmd_valid & ~decerr & fifo_full_n}} & sel_oh;
  assign s_icb_cmd_ready = fifo_full_n & (decerr | cmd_ready_sel);
  assign cmd_fire        = s_icb_cmd_valid & s_icb_cmd_ready;

  assign route_in.decerr = decerr;
  assign route_in.sel    = sel;

  icb_route_fifo #(
    .DEPTH   (OUTSTD_DEPTH)
  ) u_route_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (cmd_fire),
    .din     (route_in),
    .pop     (rsp_fire),
    .head    (head),
    .full_n  (fifo_full_n),
    .empty_n (head_vld),
    .count   (outstd_cnt)
  );

  // Response mux driven by the FIFO head; other masters stay stalled.
  always_comb begin
    s_icb_rsp_valid = 1'b0;
    s_icb_rsp_rdata = '0;
    s_icb_rsp_err   = 1'b0;
    m_icb_rsp_ready = '0;
    if (head_vld) begin
      if (head.decerr) begin
        s_icb_rsp_valid = 1'b1;
        s_icb_rsp_err   = 1'b1;
      end else begin
        for (int i = 0; i < MASTER_N; i++) begin
          if (head.sel == SEL_W'(i)) begin
            s_icb_rsp_valid    = m_icb_rsp_valid[i];
            s_icb_rsp_rdata    = m_icb_rsp_rdata[DATA_W*i +: DATA_W];
            s_icb_rsp_err      = m_icb_rsp_err[i];
            m_icb_rsp_ready[i] = s_icb_rsp_ready;
          end
        end
      end
    end
  end

  assign rsp_fire = s_icb_rsp_valid & s_icb_rsp_ready;

  // One-cycle flag for each accepted unmapped command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      decerr_pulse <= 1'b0;
    else
      decerr_pulse <= cmd_fire & decerr;
  end

endmodule

// File: doc/icb_1s_to_nm.md
# icb_1s_to_nm

Parametrised ICB one-slave-to-N-master address splitter. It extends the fixed three-way splitter to 2..8 downstream masters and a configurable outstanding-transaction depth. It also terminates decode errors locally with an error response instead of leaving them unhandled. It sits between a core's data ICB port and the SoC peripheral/memory ICB segments.

## Interface
- MASTER_N, 3: number of downstream masters, 2..8.
- BASEADDR, {8{32'h0}}: packed 8×32, base address of master i at bits [32i+31:32i].
- ADDR_RANGE, {8{32'h1000}}: packed 8×32, region length of master i, nonzero. Overlaps are resolved by lowest index.
- OUTSTD_DEPTH, 4: routing-FIFO depth, power of two, 2..16.
- DECERR_EN, 1: 1 = unmapped addresses get a local error response; 0 = unmapped commands route to master MASTER_N-1.
- simulation_delay, 1: register update delay, simulation only.
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- s_icb_cmd_addr/read/wdata/wmask/valid  in  32/1/32/4/1  upstream command.
- s_icb_cmd_ready  out  1
- s_icb_rsp_rdata/err/valid  out  32/1/1  upstream response.
- s_icb_rsp_ready  in  1
- m_icb_cmd_addr/read/wdata/wmask  out  MASTER_N×(32/1/32/4)  packed downstream commands, all copies of s_*.
- m_icb_cmd_valid  out  MASTER_N
- m_icb_cmd_ready  in  MASTER_N
- m_icb_rsp_rdata/err/valid  in  MASTER_N×(32/1/1)
- m_icb_rsp_ready  out  MASTER_N
- outstd_cnt  out  5  entries currently in the routing FIFO.
- decerr_pulse  out  1  registered one-cycle pulse per accepted unmapped command.

## Operation
- Decode (combinational): hit[i] = addr ≥ BASEADDR[i] && addr < BASEADDR[i]+ADDR_RANGE[i], compared in 33-bit arithmetic so no wrap occurs. The routing index is the lowest hit. If there is no hit: decerr = DECERR_EN; otherwise the command goes to index MASTER_N-1.
- Command path:
  - m_icb_cmd_valid[i] = s_valid & sel==i & !decerr & fifo_not_full.
  - s_icb_cmd_ready = fifo_not_full & (decerr | m_icb_cmd_ready[sel]).
  - A decerr command is never presented downstream.
- Routing FIFO entry = {decerr, sel[2:0]}. It is pushed on every upstream command handshake and popped on every upstream response handshake. The FIFO is first-word-fall-through and registered: an entry is visible at the head the cycle after its push.
- Response path (in order, head-driven):
  - Head is a normal entry: s_rsp_* = m_rsp_*[head.sel] and m_icb_rsp_ready[head.sel] = s_rsp_ready. All other m_icb_rsp_ready bits are 0.
  - Head is a decerr entry: s_rsp_valid = 1, rdata = 32'h0, err = 1. No downstream ready is asserted.
  - FIFO empty: s_rsp_valid = 0 and all m_icb_rsp_ready = 0.
- Responses from a master that is not at the FIFO head stay stalled, because their ready is 0.
- outstd_cnt: counter, +1 on push, -1 on pop, unchanged on simultaneous push and pop.

## Timing
- Command latency is 0 (combinational passthrough).
- Response is stalled until the matching entry reaches the head. The minimum is 1 cycle after the command handshake; a zero-latency downstream response is held by ICB valid-hold rules.
- A decerr response is valid at the earliest 1 cycle after acceptance.
- Full FIFO: s_cmd_ready = 0 and all m_cmd_valid = 0.
- Full FIFO with a pop in the same cycle: a push is still refused that cycle. The full flag is registered.
- Empty FIFO with a push: no response is forwarded that cycle.
- On reset, or reset asserted mid-transfer:
  - FIFO is flushed, outstd_cnt = 0 and decerr_pulse = 0.
  - s_rsp_valid = 0 and all m_rsp_ready = 0.
  - In-flight downstream responses are dropped. The system resets masters together with this block.

## Structure
- Shared package icb_pkg: ICB field widths (ADDR_W = 32, DATA_W = 32, MASK_W = 4) and a route-entry struct {decerr, sel}.
- Sub-module icb_route_fifo:
  - Register-based FWFT FIFO, depth OUTSTD_DEPTH, width 4.
  - Registered full_n and empty_n flags, and a count output.
  - Pointer wrap at OUTSTD_DEPTH.
- Top level: decode, muxes and decerr_pulse register, about 200 lines total.

## Test plan
- Test setup: MASTER_N = 4, depth 4, bases 0x1000_0000, 0x2000_0000, 0x4000_0000, 0xF000_0000, ranges 0x1000.
- Read 0x2000_0010 → m_cmd_valid = 4'b0010. Master 1 returns 0xA5A5_A5A5 after 3 cycles → s_rsp rdata 0xA5A5_A5A5, err = 0, outstd_cnt goes 1 → 0.
- Write to 0x3000_0000 → accepted with no m_cmd_valid and decerr_pulse = 1. The next cycle gives s_rsp_valid = 1, err = 1, rdata = 0.
- Out-of-order downstream: commands to master 0 then master 2, with master 2 responding first → master 2 is stalled until master 0's response completes. The upstream order is preserved.
- Five back-to-back commands to master 3 with responses withheld → the 5th command sees s_cmd_ready = 0 and outstd_cnt = 4. Releasing one response lets the 5th command be accepted the following cycle.
- Boundary addresses: 0x1000_0FFF hits master 0; 0x1000_1000 is a decerr; 0xFFFF_FFFF with base 0xFFFF_F000 and range 0x1000 hits without wrap.
- Reset asserted with 3 entries outstanding → outstd_cnt = 0 and s_rsp_valid = 0 immediately (asynchronous). A new read after reset is released is routed normally.
